// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer.
//   Allocation : dec_valid/dec_reg_id/dec_is_branch in; dec_rob_id (tail), full out.
//   Writeback  : cdb_valid/cdb_rob_id/cdb_data/cdb_mispredict/cdb_target_pc in.
//   Lookup     : rob_rob_id_j/k in; rob_ready_j/k, rob_data_j/k out (comb, with CDB bypass).
//   Commit     : commit_reg_id/commit_data/commit_rob_id registered single-cycle pulse.
//   Flush      : flush/flush_pc registered, raised when a mispredicted branch retires.
//   rdy_in low freezes every register in the block.
module reorder_buffer #(
  parameter int ROB_WIDTH = 3,
  parameter int REG_WIDTH = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 dec_valid,
  input  logic [REG_WIDTH-1:0] dec_reg_id,
  input  logic                 dec_is_branch,
  output logic [ROB_WIDTH-1:0] dec_rob_id,
  output logic                 full,
  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_rob_id,
  input  logic [31:0]          cdb_data,
  input  logic                 cdb_mispredict,
  input  logic [31:0]          cdb_target_pc,
  input  logic [ROB_WIDTH-1:0] rob_rob_id_j,
  input  logic [ROB_WIDTH-1:0] rob_rob_id_k,
  output logic                 rob_ready_j,
  output logic                 rob_ready_k,
  output logic [31:0]          rob_data_j,
  output logic [31:0]          rob_data_k,
  output logic [REG_WIDTH-1:0] commit_reg_id,
  output logic [31:0]          commit_data,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 flush,
  output logic [31:0]          flush_pc
);
  localparam int ROB_SIZE = 1 << ROB_WIDTH;

  // Per-entry flags (reset) and payload arrays (no reset needed: guarded by busy/ready).
  logic [ROB_SIZE-1:0]  busy_q, busy_d, ready_q, ready_d, br_q, br_d, mis_q, mis_d;
  logic [REG_WIDTH-1:0] dest_q  [ROB_SIZE];
  logic [31:0]          value_q [ROB_SIZE];
  logic [31:0]          tpc_q   [ROB_SIZE];

  logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;

  logic [REG_WIDTH-1:0] commit_reg_q, commit_reg_d;
  logic [31:0]          commit_data_q, commit_data_d;
  logic [ROB_WIDTH-1:0] commit_id_q, commit_id_d;
  logic                 flush_q, flush_d;
  logic [31:0]          flush_pc_q, flush_pc_d;

  logic issue, wb, do_commit, mispred;

  assign full       = (count_q == (ROB_WIDTH+1)'(ROB_SIZE));
  assign dec_rob_id = tail_q;

  // Full is sampled before any same-cycle retirement, so a freed slot is only
  // visible to the decoder on the following cycle.
  assign issue     = dec_valid && !full && !flush_q;
  assign wb        = cdb_valid && busy_q[cdb_rob_id] && !flush_q;
  assign do_commit = busy_q[head_q] && ready_q[head_q] && !flush_q;
  assign mispred   = do_commit && br_q[head_q] && mis_q[head_q];

  always_comb begin
    busy_d        = busy_q;
    ready_d       = ready_q;
    br_d          = br_q;
    mis_d         = mis_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    commit_reg_d  = '0;
    commit_data_d = commit_data_q;
    commit_id_d   = commit_id_q;
    flush_d       = 1'b0;
    flush_pc_d    = flush_pc_q;

    if (issue) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      br_d[tail_q]    = dec_is_branch;
      mis_d[tail_q]   = 1'b0;
      tail_d          = tail_q + 1'b1;
    end

    if (wb) begin
      ready_d[cdb_rob_id] = 1'b1;
      mis_d[cdb_rob_id]   = cdb_mispredict;
    end

    if (do_commit) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
      commit_reg_d   = br_q[head_q] ? '0 : dest_q[head_q];
      commit_data_d  = value_q[head_q];
      commit_id_d    = head_q;
    end

    if (issue && !do_commit)
      count_d = count_q + 1'b1;
    else if (!issue && do_commit)
      count_d = count_q - 1'b1;

    // A retiring mispredicted branch discards everything younger, including
    // anything allocated on this same edge.
    if (mispred) begin
      busy_d     = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      flush_d    = 1'b1;
      flush_pc_d = tpc_q[head_q];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q        <= '0;
      ready_q       <= '0;
      br_q          <= '0;
      mis_q         <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commit_reg_q  <= '0;
      commit_data_q <= '0;
      commit_id_q   <= '0;
      flush_q       <= 1'b0;
      flush_pc_q    <= '0;
    end else if (rdy_in) begin
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      br_q          <= br_d;
      mis_q         <= mis_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commit_reg_q  <= commit_reg_d;
      commit_data_q <= commit_data_d;
      commit_id_q   <= commit_id_d;
      flush_q       <= flush_d;
      flush_pc_q    <= flush_pc_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (issue)
        dest_q[tail_q] <= dec_reg_id;
      if (wb) begin
        value_q[cdb_rob_id] <= cdb_data;
        tpc_q[cdb_rob_id]   <= cdb_target_pc;
      end
    end
  end

  assign commit_reg_id = commit_reg_q;
  assign commit_data   = commit_data_q;
  assign commit_rob_id = commit_id_q;
  assign flush         = flush_q;
  assign flush_pc      = flush_pc_q;

  // Two identical lookup ports; a result on the CDB this cycle is forwarded
  // before it lands in the entry.
  logic [ROB_WIDTH-1:0] lk_id    [2];
  logic                 lk_ready [2];
  logic [31:0]          lk_data  [2];

  assign lk_id[0] = rob_rob_id_j;
  assign lk_id[1] = rob_rob_id_k;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
    always_comb begin
      lk_ready[gi] = 1'b0;
      lk_data[gi]  = '0;
      if (busy_q[lk_id[gi]] && ready_q[lk_id[gi]]) begin
        lk_ready[gi] = 1'b1;
        lk_data[gi]  = value_q[lk_id[gi]];
      end else if (cdb_valid && cdb_rob_id == lk_id[gi]) begin
        lk_ready[gi] = 1'b1;
        lk_data[gi]  = cdb_data;
      end
    end
  end

  assign rob_ready_j = lk_ready[0];
  assign rob_data_j  = lk_data[0];
  assign rob_ready_k = lk_ready[1];
  assign rob_data_k  = lk_data[1];

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a vector table for the basic issue /
// writeback / in-order commit flow, plus hand-written multi-cycle sequences
// for reset, full/wrap, CDB bypass, mispredict flush and rdy_in stalls.
module tb_reorder_buffer;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        dec_valid;
  logic [4:0]  dec_reg_id;
  logic        dec_is_branch;
  logic [2:0]  dec_rob_id;
  logic        full;
  logic        cdb_valid;
  logic [2:0]  cdb_rob_id;
  logic [31:0] cdb_data;
  logic        cdb_mispredict;
  logic [31:0] cdb_target_pc;
  logic [2:0]  rob_rob_id_j, rob_rob_id_k;
  logic        rob_ready_j, rob_ready_k;
  logic [31:0] rob_data_j, rob_data_k;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_data;
  logic [2:0]  commit_rob_id;
  logic        flush;
  logic [31:0] flush_pc;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_valid(dec_valid), .dec_reg_id(dec_reg_id), .dec_is_branch(dec_is_branch),
    .dec_rob_id(dec_rob_id), .full(full),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict), .cdb_target_pc(cdb_target_pc),
    .rob_rob_id_j(rob_rob_id_j), .rob_rob_id_k(rob_rob_id_k),
    .rob_ready_j(rob_ready_j), .rob_ready_k(rob_ready_k),
    .rob_data_j(rob_data_j), .rob_data_k(rob_data_k),
    .commit_reg_id(commit_reg_id), .commit_data(commit_data),
    .commit_rob_id(commit_rob_id), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        dv;
    logic [4:0]  dreg;
    logic        dbr;
    logic        cv;
    logic [2:0]  cid;
    logic [31:0] cdata;
    logic        cmis;
    logic [31:0] ctpc;
    logic        e_full;
    logic [2:0]  e_tail;
    logic [4:0]  e_creg;
    logic        chk_c;
    logic [31:0] e_cdata;
    logic [2:0]  e_cid;
    logic        e_flush;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t v(input logic dv, input logic [4:0] dreg, input logic dbr,
                             input logic cv, input logic [2:0] cid, input logic [31:0] cdata,
                             input logic cmis, input logic [31:0] ctpc,
                             input logic e_full, input logic [2:0] e_tail, input logic [4:0] e_creg,
                             input logic chk_c, input logic [31:0] e_cdata, input logic [2:0] e_cid,
                             input logic e_flush);
    vec_t r;
    r.dv = dv; r.dreg = dreg; r.dbr = dbr;
    r.cv = cv; r.cid = cid; r.cdata = cdata; r.cmis = cmis; r.ctpc = ctpc;
    r.e_full = e_full; r.e_tail = e_tail; r.e_creg = e_creg;
    r.chk_c = chk_c; r.e_cdata = e_cdata; r.e_cid = e_cid; r.e_flush = e_flush;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; dec_valid = 1'b0; dec_reg_id = '0; dec_is_branch = 1'b0;
    cdb_valid = 1'b0; cdb_rob_id = '0; cdb_data = '0; cdb_mispredict = 1'b0;
    cdb_target_pc = '0; rob_rob_id_j = '0; rob_rob_id_k = '0;
  endtask

  task automatic issue(input logic [4:0] r, input logic br);
    dec_valid = 1'b1; dec_reg_id = r; dec_is_branch = br;
  endtask

  task automatic cdb(input logic [2:0] id, input logic [31:0] d, input logic mis, input logic [31:0] tpc);
    cdb_valid = 1'b1; cdb_rob_id = id; cdb_data = d; cdb_mispredict = mis; cdb_target_pc = tpc;
  endtask

  // Called just after a clock edge; pulses reset between edges.
  task automatic reset_pulse();
    idle_inputs();
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
    tick();
  endtask

  initial begin
    idle_inputs();
    rst_in = 1'b1;
    #1;
    chk("rst_full", 32'(full), 0);
    chk("rst_tail", 32'(dec_rob_id), 0);
    chk("rst_creg", 32'(commit_reg_id), 0);
    chk("rst_cdata", commit_data, 0);
    chk("rst_cid", 32'(commit_rob_id), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_flush_pc", flush_pc, 0);
    tick();
    rst_in = 1'b0;
    tick();

    // Reset in the middle of operation with three entries still busy.
    for (int i = 0; i < 4; i++) begin
      issue(5'(i + 1), 1'b0);
      tick();
    end
    idle_inputs();
    cdb(3'd0, 32'hAA, 1'b0, 0);
    tick();
    idle_inputs();
    tick();
    chk("mid_commit_creg", 32'(commit_reg_id), 1);
    chk("mid_tail", 32'(dec_rob_id), 4);
    #2;
    rst_in = 1'b1;
    #1;
    chk("async_rst_full", 32'(full), 0);
    chk("async_rst_tail", 32'(dec_rob_id), 0);
    chk("async_rst_creg", 32'(commit_reg_id), 0);
    chk("async_rst_flush", 32'(flush), 0);
    $display("reset mid-operation: tail=%0d creg=%0d", dec_rob_id, commit_reg_id);
    rst_in = 1'b0;
    tick();

    // Table: out-of-order completion, in-order retirement, non-mispredicted branch.
    vecs[0]  = v(1, 1, 0, 0, 0, 0,     0, 0,     0, 1, 0, 0, 0,     0, 0);
    vecs[1]  = v(1, 2, 0, 0, 0, 0,     0, 0,     0, 2, 0, 0, 0,     0, 0);
    vecs[2]  = v(1, 3, 0, 0, 0, 0,     0, 0,     0, 3, 0, 0, 0,     0, 0);
    vecs[3]  = v(0, 0, 0, 1, 2, 'h33,  0, 0,     0, 3, 0, 0, 0,     0, 0);
    vecs[4]  = v(0, 0, 0, 1, 0, 'h11,  0, 0,     0, 3, 0, 0, 0,     0, 0);
    vecs[5]  = v(0, 0, 0, 1, 1, 'h22,  0, 0,     0, 3, 1, 1, 'h11,  0, 0);
    vecs[6]  = v(0, 0, 0, 0, 0, 0,     0, 0,     0, 3, 2, 1, 'h22,  1, 0);
    vecs[7]  = v(0, 0, 0, 0, 0, 0,     0, 0,     0, 3, 3, 1, 'h33,  2, 0);
    vecs[8]  = v(0, 0, 0, 0, 0, 0,     0, 0,     0, 3, 0, 0, 0,     0, 0);
    vecs[9]  = v(1, 9, 1, 0, 0, 0,     0, 0,     0, 4, 0, 0, 0,     0, 0);
    vecs[10] = v(0, 0, 0, 1, 3, 'h44,  0, 'h200, 0, 4, 0, 0, 0,     0, 0);
    vecs[11] = v(0, 0, 0, 0, 0, 0,     0, 0,     0, 4, 0, 1, 'h44,  3, 0);
    vecs[12] = v(0, 0, 0, 0, 0, 0,     0, 0,     0, 4, 0, 0, 0,     0, 0);

    for (int i = 0; i < 13; i++) begin
      idle_inputs();
      dec_valid = vecs[i].dv; dec_reg_id = vecs[i].dreg; dec_is_branch = vecs[i].dbr;
      cdb_valid = vecs[i].cv; cdb_rob_id = vecs[i].cid; cdb_data = vecs[i].cdata;
      cdb_mispredict = vecs[i].cmis; cdb_target_pc = vecs[i].ctpc;
      tick();
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d_tail", i), 32'(dec_rob_id), 32'(vecs[i].e_tail));
      chk($sformatf("vec%0d_creg", i), 32'(commit_reg_id), 32'(vecs[i].e_creg));
      chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
      if (vecs[i].chk_c) begin
        chk($sformatf("vec%0d_cdata", i), commit_data, vecs[i].e_cdata);
        chk($sformatf("vec%0d_cid", i), 32'(commit_rob_id), 32'(vecs[i].e_cid));
      end
      $display("vec %0d: tail=%0d creg=%0d cdata=%0h cid=%0d", i, dec_rob_id,
               commit_reg_id, commit_data, commit_rob_id);
    end

    // Mispredicted branch at id0 with two younger entries behind it.
    reset_pulse();
    issue(5'd7, 1'b1); tick();
    issue(5'd4, 1'b0); tick();
    issue(5'd5, 1'b0); tick();
    idle_inputs();
    cdb(3'd0, 32'h55, 1'b1, 32'h100);
    tick();
    chk("br_pre_flush", 32'(flush), 0);
    idle_inputs();
    tick();
    chk("br_flush", 32'(flush), 1);
    chk("br_flush_pc", flush_pc, 32'h100);
    chk("br_creg", 32'(commit_reg_id), 0);
    chk("br_tail", 32'(dec_rob_id), 0);
    $display("mispredict commit: flush=%0d flush_pc=%0h", flush, flush_pc);
    issue(5'd6, 1'b0);
    cdb(3'd1, 32'h77, 1'b0, 0);
    tick();
    chk("post_flush_drop", 32'(flush), 0);
    chk("post_flush_tail", 32'(dec_rob_id), 0);
    chk("post_flush_full", 32'(full), 0);
    idle_inputs();
    rob_rob_id_j = 3'd1;
    #1;
    chk("post_flush_lookup", 32'(rob_ready_j), 0);
    issue(5'd6, 1'b0); tick();
    chk("post_flush_issue_tail", 32'(dec_rob_id), 1);
    idle_inputs();
    cdb(3'd0, 32'h66, 1'b0, 0); tick();
    idle_inputs(); tick();
    chk("post_flush_commit_reg", 32'(commit_reg_id), 6);
    chk("post_flush_commit_data", commit_data, 32'h66);

    // Fill to full, refused issue, wrap.
    reset_pulse();
    for (int i = 0; i < 8; i++) begin
      issue(5'(i + 1), 1'b0);
      tick();
      chk($sformatf("fill%0d_tail", i), 32'(dec_rob_id), 32'((i + 1) % 8));
      chk($sformatf("fill%0d_full", i), 32'(full), (i == 7) ? 1 : 0);
    end
    issue(5'd9, 1'b0); tick();
    chk("ninth_full", 32'(full), 1);
    chk("ninth_tail", 32'(dec_rob_id), 0);
    idle_inputs();
    cdb(3'd0, 32'hA0, 1'b0, 0); tick();
    idle_inputs();
    issue(5'd10, 1'b0);
    #1;
    chk("full_before_commit", 32'(full), 1);
    tick();
    chk("refused_commit_reg", 32'(commit_reg_id), 1);
    chk("refused_commit_data", commit_data, 32'hA0);
    chk("refused_tail", 32'(dec_rob_id), 0);
    chk("refused_full", 32'(full), 0);
    issue(5'd11, 1'b0); tick();
    chk("wrap_tail", 32'(dec_rob_id), 1);
    chk("wrap_full", 32'(full), 1);
    $display("wrap: tail=%0d full=%0d", dec_rob_id, full);

    // Same-cycle CDB bypass on lookup, then value from the entry.
    idle_inputs();
    cdb(3'd4, 32'hDEAD, 1'b0, 0);
    rob_rob_id_j = 3'd4;
    rob_rob_id_k = 3'd5;
    #1;
    chk("bypass_ready_j", 32'(rob_ready_j), 1);
    chk("bypass_data_j", rob_data_j, 32'hDEAD);
    chk("bypass_ready_k", 32'(rob_ready_k), 0);
    chk("bypass_data_k", rob_data_k, 0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("entry_ready_j", 32'(rob_ready_j), 1);
    chk("entry_data_j", rob_data_j, 32'hDEAD);
    $display("lookup id4: ready=%0d data=%0h", rob_ready_j, rob_data_j);

    // rdy_in stall with a committable head.
    idle_inputs();
    cdb(3'd1, 32'h1111, 1'b0, 0); tick();
    chk("stall_pre_creg", 32'(commit_reg_id), 0);
    cdb(3'd2, 32'h2222, 1'b0, 0); tick();
    chk("stall_c1_reg", 32'(commit_reg_id), 2);
    chk("stall_c1_data", commit_data, 32'h1111);
    chk("stall_c1_id", 32'(commit_rob_id), 1);
    idle_inputs();
    rdy_in = 1'b0;
    cdb(3'd3, 32'h3333, 1'b0, 0);
    issue(5'd12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_creg", i), 32'(commit_reg_id), 2);
      chk($sformatf("stall%0d_cdata", i), commit_data, 32'h1111);
      chk($sformatf("stall%0d_cid", i), 32'(commit_rob_id), 1);
      chk($sformatf("stall%0d_tail", i), 32'(dec_rob_id), 1);
      $display("stall %0d: creg=%0d tail=%0d", i, commit_reg_id, dec_rob_id);
    end
    idle_inputs(); tick();
    chk("resume_creg", 32'(commit_reg_id), 3);
    chk("resume_cdata", commit_data, 32'h2222);
    chk("resume_cid", 32'(commit_rob_id), 2);
    tick();
    chk("resume_idle_creg", 32'(commit_reg_id), 0);
    rob_rob_id_j = 3'd3;
    #1;
    chk("stalled_cdb_ignored", 32'(rob_ready_j), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
